// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and constants for the snn image loader
package snn_pkg;

  typedef logic [2:0] ldr_state_t;

  localparam ldr_state_t IDLE   = 3'd0;
  localparam ldr_state_t UNPACK = 3'd1;
  localparam ldr_state_t START  = 3'd2;
  localparam ldr_state_t RUN    = 3'd3;
  localparam ldr_state_t TX     = 3'd4;

  localparam int IMG_BITS  = 784;
  localparam int IMG_BYTES = 98;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/ram.sv
// rtl/ram.sv - single-port RAM with synchronous read, one cycle latency
module ram #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    q <= mem[addr];
  end

endmodule

// File: rtl/snn_img_loader.sv
// rtl/snn_img_loader.sv - unpacks a UART-delivered binary image into the core input RAM
// and returns the classified digit as an ASCII byte.
module snn_img_loader #(
  parameter int IMG_BITS  = snn_pkg::IMG_BITS,
  parameter int IMG_BYTES = snn_pkg::IMG_BYTES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       snn_start,
  input  logic       snn_done,
  input  logic [3:0] digit,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy
);

  import snn_pkg::*;

  // Load stops at whichever bound is tighter, so a mis-set pair cannot overrun the RAM map.
  localparam int LoadBits = (IMG_BITS < IMG_BYTES * 8) ? IMG_BITS : IMG_BYTES * 8;
  localparam logic [9:0] LastAddr = 10'(LoadBits - 1);

  ldr_state_t state;
  ldr_state_t next_state;
  logic [9:0] wr_addr;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       ram_we;
  logic [9:0] ram_addr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rx_rdy) next_state = UNPACK;
      UNPACK:  if (bit_cnt == 3'd7) next_state = (wr_addr == LastAddr) ? START : IDLE;
      START:   next_state = RUN;
      RUN:     if (snn_done) next_state = TX;
      TX:      if (!tx_busy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_addr <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tx_data <= '0;
      busy    <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == START) || (next_state == RUN) || (next_state == TX);
      case (state)
        IDLE: if (rx_rdy) shreg <= rx_data;
        UNPACK: begin
          shreg   <= {1'b0, shreg[7:1]};
          wr_addr <= wr_addr + 10'd1;
          bit_cnt <= bit_cnt + 3'd1;
        end
        START: wr_addr <= '0;
        RUN: if (snn_done) tx_data <= ASCII_ZERO + {4'h0, digit};
        default: ;
      endcase
    end
  end

  assign ram_we    = (state == UNPACK);
  assign ram_addr  = (state == IDLE || state == UNPACK) ? wr_addr : addr_input_unit;
  assign snn_start = (state == START);
  assign tx_start  = (state == TX) && !tx_busy;

  ram #(
    .DATA_WIDTH(1),
    .ADDR_WIDTH(10)
  ) ram_input_unit (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .d   (shreg[0]),
    .q   (q_input)
  );

endmodule

// File: tb/tb_snn_img_loader.sv
// tb/tb_snn_img_loader.sv - directed scoreboard bench for snn_img_loader
module tb_snn_img_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       snn_start;
  logic       snn_done;
  logic [3:0] digit;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;

  logic [7:0] pat     [98];
  logic       img_exp [784];
  logic       q_exp   [$];
  logic [7:0] tx_exp  [$];

  snn_img_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_rdy         (rx_rdy),
    .addr_input_unit(addr_input_unit),
    .q_input        (q_input),
    .snn_start      (snn_start),
    .snn_done       (snn_done),
    .digit          (digit),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx_busy        (tx_busy),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (snn_start === 1'b1) starts++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle t+9.
  task automatic send_byte(input logic [7:0] b, input bit drop);
    rx_data = b;
    rx_rdy  = 1'b1;
    @(negedge clk);
    for (int j = 1; j <= 8; j++) begin
      if (drop && j == 3) begin
        rx_rdy  = 1'b1;
        rx_data = ~b;
      end else begin
        rx_rdy = 1'b0;
      end
      @(negedge clk);
    end
    rx_rdy = 1'b0;
  endtask

  task automatic load_image(input int drop_byte);
    for (int k = 0; k < 98; k++)
      for (int i = 0; i < 8; i++) img_exp[8*k+i] = pat[k][i];
    for (int k = 0; k < 98; k++) begin
      send_byte(pat[k], k == drop_byte);
      check($sformatf("snn_start_after_byte%0d", k), {15'd0, snn_start}, {15'd0, k == 97});
    end
    check("busy_in_start", {15'd0, busy}, 16'd1);
    @(negedge clk);
    check("snn_start_one_cycle", {15'd0, snn_start}, 16'd0);
    check("busy_in_run", {15'd0, busy}, 16'd1);
  endtask

  task automatic read_px(input int a);
    addr_input_unit = 10'(a);
    q_exp.push_back(img_exp[a]);
    @(negedge clk);
    check($sformatf("q_input_addr%0d", a), {15'd0, q_input}, {15'd0, q_exp.pop_front()});
  endtask

  task automatic readback_all();
    for (int a = 0; a < 784; a++) read_px(a);
  endtask

  task automatic do_result(input logic [3:0] d, input int busy_cycles);
    int early;
    early = 0;
    tx_busy = (busy_cycles > 0);
    snn_done = 1'b1;
    digit = d;
    tx_exp.push_back(8'h30 + {4'h0, d});
    @(negedge clk);
    snn_done = 1'b0;
    digit = 4'hx;
    for (int n = 0; n < busy_cycles; n++) begin
      if (tx_start !== 1'b0 || busy !== 1'b1) early++;
      @(negedge clk);
    end
    if (busy_cycles > 0) begin
      check("tx_held_while_busy", 16'(early), 16'd0);
      tx_busy = 1'b0;
      #1;
    end
    check("tx_start_pulse", {15'd0, tx_start}, 16'd1);
    check("busy_in_tx", {15'd0, busy}, 16'd1);
    check("tx_data", {8'd0, tx_data}, {8'd0, tx_exp.pop_front()});
    @(negedge clk);
    check("tx_start_one_cycle", {15'd0, tx_start}, 16'd0);
    check("busy_idle_after_tx", {15'd0, busy}, 16'd0);
    check("tx_data_held", {8'd0, tx_data}, {8'h00, 8'h30 + {4'h0, d}});
  endtask

  initial begin
    rst_n = 1'b1;
    rx_data = 8'h00;
    rx_rdy = 1'b0;
    addr_input_unit = 10'd0;
    snn_done = 1'b0;
    digit = 4'd0;
    tx_busy = 1'b0;

    #12 rst_n = 1'b0;
    #1;
    check("rst_snn_start", {15'd0, snn_start}, 16'd0);
    check("rst_tx_start", {15'd0, tx_start}, 16'd0);
    check("rst_tx_data", {8'd0, tx_data}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Image 1: 0xA5 everywhere, a stray byte mid-unpack, stray bytes during RUN.
    for (int k = 0; k < 98; k++) pat[k] = 8'hA5;
    load_image(10);
    read_px(0);
    read_px(1);
    read_px(783);
    readback_all();
    for (int n = 0; n < 3; n++) begin
      rx_data = 8'h5A;
      rx_rdy = 1'b1;
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
    end
    check("busy_after_run_drop", {15'd0, busy}, 16'd1);
    do_result(4'd7, 0);

    // Partial load, then reset in the middle of an unpack.
    for (int k = 0; k < 50; k++) send_byte(8'h00, 1'b0);
    rx_data = 8'h00;
    rx_rdy = 1'b1;
    @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_snn_start", {15'd0, snn_start}, 16'd0);
    check("midrst_tx_data", {8'd0, tx_data}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Image 2: all ones, result with a long busy UART.
    for (int k = 0; k < 98; k++) pat[k] = 8'hFF;
    load_image(-1);
    readback_all();
    do_result(4'd3, 100);

    // Image 3: random pattern, back to back.
    for (int k = 0; k < 98; k++) pat[k] = 8'($urandom);
    load_image(-1);
    readback_all();
    do_result(4'd9, 0);

    // A done pulse outside RUN must not transmit.
    snn_done = 1'b1;
    digit = 4'd2;
    @(negedge clk);
    snn_done = 1'b0;
    check("done_in_idle_no_tx", {15'd0, tx_start}, 16'd0);
    check("done_in_idle_tx_data", {8'd0, tx_data}, 16'h0039);
    @(negedge clk);
    check("done_in_idle_busy", {15'd0, busy}, 16'd0);

    check("total_start_pulses", 16'(starts), 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
